// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, ALU op encodings, operand-source codes and issue-slot type
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int OP_W   = 5;

    // ALU operation encodings; NOP is the value carried by bubbles
    localparam logic [OP_W-1:0] ALU_NOP  = 5'd0;
    localparam logic [OP_W-1:0] ALU_ADDU = 5'd1;
    localparam logic [OP_W-1:0] ALU_SUBU = 5'd2;
    localparam logic [OP_W-1:0] ALU_AND  = 5'd3;
    localparam logic [OP_W-1:0] ALU_OR   = 5'd4;
    localparam logic [OP_W-1:0] ALU_XOR  = 5'd5;
    localparam logic [OP_W-1:0] ALU_NOR  = 5'd6;
    localparam logic [OP_W-1:0] ALU_SLT  = 5'd7;
    localparam logic [OP_W-1:0] ALU_SLTU = 5'd8;
    localparam logic [OP_W-1:0] ALU_SLL  = 5'd9;
    localparam logic [OP_W-1:0] ALU_SRL  = 5'd10;
    localparam logic [OP_W-1:0] ALU_SRA  = 5'd11;
    localparam logic [OP_W-1:0] ALU_SLLV = 5'd12;
    localparam logic [OP_W-1:0] ALU_SRLV = 5'd13;
    localparam logic [OP_W-1:0] ALU_SRAV = 5'd14;
    localparam logic [OP_W-1:0] ALU_LUI  = 5'd15;

    // A-operand sources
    localparam logic [1:0] ASRC_RS       = 2'd0;
    localparam logic [1:0] ASRC_SHAMT    = 2'd1;
    localparam logic [1:0] ASRC_RS_SHAMT = 2'd2;
    localparam logic [1:0] ASRC_ZERO     = 2'd3;

    // B-operand sources
    localparam logic BSRC_RT  = 1'b0;
    localparam logic BSRC_IMM = 1'b1;

    // Contents of the ID/EX issue register
    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   alu_op;
        logic [1:0]        asrc;
        logic              bsrc;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
    } issue_t;

    // Bubble: nothing valid, NOP op, all indices and operand data cleared
    function automatic issue_t issue_bubble();
        issue_t b;
        b        = '0;
        b.alu_op = ALU_NOP;
        return b;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-operand forwarding compare/select (active with ALU_ISSUE_FWD_EN)
module fwd_mux
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0]  idx,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              em_reg_write,
    input  logic [REG_W-1:0]  em_rd,
    input  logic [DATA_W-1:0] em_result,
    input  logic              mw_reg_write,
    input  logic [REG_W-1:0]  mw_rd,
    input  logic [DATA_W-1:0] mw_result,
    output logic [DATA_W-1:0] data
);

`ifdef ALU_ISSUE_FWD_EN
    logic em_hit;
    logic mw_hit;

    // Register 0 is hardwired, so it never matches a producer; EX/MEM is younger and wins
    always_comb begin
        em_hit = em_reg_write && (em_rd == idx) && (idx != '0);
        mw_hit = mw_reg_write && (mw_rd == idx) && (idx != '0);
        data   = reg_data;
        if (em_hit) begin
            data = em_result;
        end else if (mw_hit) begin
            data = mw_result;
        end
    end
`else
    logic unused_fwd_inputs;

    // Forwarding compiled out: operand is the registered value only
    always_comb begin
        data              = reg_data;
        unused_fwd_inputs = ^{idx, em_reg_write, em_rd, em_result,
                              mw_reg_write, mw_rd, mw_result};
    end
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue register with operand forwarding (optional: ALU_ISSUE_FWD_EN)
module alu_issue_stage
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_alu_op,
    input  logic [1:0]        id_asrc,
    input  logic              id_bsrc,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm32,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_reg_write,
    input  logic              em_reg_write,
    input  logic [REG_W-1:0]  em_rd,
    input  logic [DATA_W-1:0] em_result,
    input  logic              mw_reg_write,
    input  logic [REG_W-1:0]  mw_rd,
    input  logic [DATA_W-1:0] mw_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_A,
    output logic [DATA_W-1:0] ex_B,
    output logic [OP_W-1:0]   ex_alu_op,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_reg_write
);

    issue_t            issue_q;
    issue_t            issue_d;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    fwd_mux u_fwd_rs (
        .idx          (issue_q.rs),
        .reg_data     (issue_q.rs_data),
        .em_reg_write (em_reg_write),
        .em_rd        (em_rd),
        .em_result    (em_result),
        .mw_reg_write (mw_reg_write),
        .mw_rd        (mw_rd),
        .mw_result    (mw_result),
        .data         (fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .idx          (issue_q.rt),
        .reg_data     (issue_q.rt_data),
        .em_reg_write (em_reg_write),
        .em_rd        (em_rd),
        .em_result    (em_result),
        .mw_reg_write (mw_reg_write),
        .mw_rd        (mw_rd),
        .mw_result    (mw_result),
        .data         (fwd_rt)
    );

    // Next issue-slot contents: flush beats stall beats load; an invalid ID slot loads a bubble
    always_comb begin
        issue_d = issue_q;
        if (flush) begin
            issue_d = issue_bubble();
        end else if (stall) begin
`ifdef ALU_ISSUE_FWD_EN
            // Capture forwarded values so a producer that retires during the stall is kept
            issue_d.rs_data = fwd_rs;
            issue_d.rt_data = fwd_rt;
`endif
        end else if (id_valid) begin
            issue_d.valid     = 1'b1;
            issue_d.alu_op    = id_alu_op;
            issue_d.asrc      = id_asrc;
            issue_d.bsrc      = id_bsrc;
            issue_d.rs        = id_rs;
            issue_d.rt        = id_rt;
            issue_d.rd        = id_rd;
            issue_d.reg_write = id_reg_write;
            issue_d.rs_data   = id_rs_data;
            issue_d.rt_data   = id_rt_data;
            issue_d.imm       = id_imm32;
        end else begin
            issue_d = issue_bubble();
        end
    end

    // Issue register; reset drops any held instruction and shows a bubble at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_q <= issue_bubble();
        end else begin
            issue_q <= issue_d;
        end
    end

    // Operand selection on top of forwarded register values; shift amounts land in [10:6]
    always_comb begin
        ex_A = '0;
        case (issue_q.asrc)
            ASRC_RS:       ex_A = fwd_rs;
            ASRC_SHAMT:    ex_A = {21'b0, issue_q.imm[10:6], 6'b0};
            ASRC_RS_SHAMT: ex_A = {21'b0, fwd_rs[4:0], 6'b0};
            default:       ex_A = '0;
        endcase
        ex_B = (issue_q.bsrc == BSRC_IMM) ? issue_q.imm : fwd_rt;
    end

    // Control outputs are squashed whenever the slot is not a real instruction
    always_comb begin
        ex_valid     = issue_q.valid;
        ex_alu_op    = issue_q.valid ? issue_q.alu_op : ALU_NOP;
        ex_rd        = issue_q.valid ? issue_q.rd : '0;
        ex_reg_write = issue_q.valid & issue_q.reg_write;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rstn  input  1  reset, asynchronous assert, active-low.
REQ-003 stall  input  1  hold current issued instruction (load-use hazard).
REQ-004 flush  input  1  replace the next register contents with a bubble (branch/jump redirect).
REQ-005 id_valid  input  1  decode stage presents a real instruction.
REQ-006 id_alu_op  input  5  ALU operation code, encodings from pipe_pkg.
REQ-007 id_asrc  input  2  A source: 0 rs, 1 shamt field, 2 rs[4:0] as shift amount.
REQ-008 id_bsrc  input  1  B source: 0 rt, 1 immediate.
REQ-009 id_rs  input  5  rs register index.
REQ-010 id_rt  input  5  rt register index.
REQ-011 id_rs_data  input  32  register-file rs value.
REQ-012 id_rt_data  input  32  register-file rt value.
REQ-013 id_imm32  input  32  extended immediate; bits [10:6] carry instruction shamt.
REQ-014 id_rd  input  5  destination index.
REQ-015 id_reg_write  input  1  instruction writes rd.
REQ-016 em_reg_write  input  1  EX/MEM producer writes.
REQ-017 em_rd  input  5  EX/MEM destination.
REQ-018 em_result  input  32  EX/MEM result.
REQ-019 mw_reg_write  input  1  MEM/WB producer writes.
REQ-020 mw_rd  input  5  MEM/WB destination.
REQ-021 mw_result  input  32  MEM/WB result.
REQ-022 ex_valid  output  1  issued slot holds a real instruction.
REQ-023 ex_A  output  32  ALU operand A; shift amount always in [10:6], other bits zero for shift sources.
REQ-024 ex_B  output  32  ALU operand B.
REQ-025 ex_alu_op  output  5  ALU operation; NOP encoding when ex_valid=0.
REQ-026 ex_rd  output  5  destination index (0 when bubble).
REQ-027 ex_reg_write  output  1  write enable, forced 0 when ex_valid=0.

Function
REQ-028 Register update priority per edge: flush > stall > load; load captures all id_* fields, id_valid=0 loads a bubble.
REQ-029 Bubble: ex_valid=0, ex_alu_op=NOP, ex_reg_write=0, ex_rd=0, operand registers 0.
REQ-030 Operand registers hold rs/rt values; ex_A/ex_B are combinational from registers plus forwarding, zero added latency (ID-to-EX one cycle).
REQ-031 Forwarding per operand: match em_reg_write && em_rd==idx && idx!=0 selects em_result, else same test on mw_* selects mw_result, else registered value; EX/MEM wins when both match.
REQ-032 Register 0 never forwarded; operand for index 0 is the registered value (0 from register file).
REQ-033 ex_A: asrc 0 -> forwarded rs; 1 -> {21'b0, imm[10:6], 6'b0}; 2 -> {21'b0, fwd_rs[4:0], 6'b0}; asrc 3 -> 0.
REQ-034 ex_B: bsrc 0 -> forwarded rt; 1 -> registered imm32.
REQ-035 During stall the operand registers reload with their currently forwarded values each cycle, so a producer retiring mid-stall is not lost; all other fields hold.
REQ-036 flush and stall in the same cycle: bubble loaded, stall ignored.

Reset
REQ-037 rstn low asynchronously forces the bubble state of REQ-029 immediately; first load on first rising edge after release; reset mid-stall discards the held instruction.

Configuration
REQ-038 ALU_ISSUE_FWD_EN defined: forwarding per REQ-031/035; undefined: operands come only from registers, em_*/mw_* ignored, stall refresh becomes plain hold.

Structure
REQ-039 pipe_pkg holds ALU op encodings (incl. NOP), ASRC/BSRC constants, register-index and data widths; forwarding compare/select is sub-module fwd_mux, instantiated once per operand.

Verification
REQ-040 Reset: rstn=0 mid-operation -> ex_valid=0, ex_alu_op=NOP, ex_A=ex_B=0 without clock edge.
REQ-041 ADDU rs=3 (data 5), em_rd=3 em_result=0x10, mw_rd=3 mw_result=0x20 -> ex_A=0x10; em_reg_write=0 -> ex_A=0x20.
REQ-042 SLL imm32=0x00000140 (shamt 5), asrc=1 -> ex_A=0x00000140; SLLV fwd rs=0x25, asrc=2 -> ex_A=0x00000140.
REQ-043 rs=0, em_rd=0 em_result=0xFFFF -> ex_A=0.
REQ-044 stall 3 cycles, producer mw_result=0x77 valid only in cycle 1 -> ex_A=0x77 after stall releases; flush+stall together -> bubble next edge.
